// File: rtl/skid_buffer_rd.sv
// skid_buffer_rd: two-entry valid/ready pipeline buffer (main + skid register).
// The consumer pulls the head word with out_ready. in_ready and out_valid are
// decoded from the state register only, so back-pressure never forms a
// combinational path between pipeline stages.
// Optional build macro SKID_BUFFER_STATS_EN adds the xfer_count and
// stall_cycles statistics outputs.
module skid_buffer_rd #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SKID_BUFFER_STATS_EN
    output logic [15:0]      xfer_count,
    output logic [15:0]      stall_cycles,
`endif
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] FULL  = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_hs, out_hs;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    // Next-state and data-path selection; flush discards everything, including a word offered in the same cycle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_hs && out_hs) begin
                        // Head leaves as the new word arrives: new word becomes head.
                        main_d = in_data;
                    end else if (in_hs) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_hs) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_hs) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef SKID_BUFFER_STATS_EN
    logic [15:0] xfer_count_q, xfer_count_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    assign xfer_count   = xfer_count_q;
    assign stall_cycles = stall_cycles_q;

    // Transfer counter wraps; stall counter saturates. Flush leaves both alone.
    always_comb begin
        xfer_count_d   = xfer_count_q;
        stall_cycles_d = stall_cycles_q;
        if (out_hs) xfer_count_d = xfer_count_q + 16'd1;
        if (out_valid && !out_ready && (stall_cycles_q != 16'hFFFF))
            stall_cycles_d = stall_cycles_q + 16'd1;
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            xfer_count_q   <= xfer_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
`endif

endmodule

// File: tb/tb_skid_buffer_rd.sv
// Self-checking bench for skid_buffer_rd: directed scenarios plus a random
// run, checked against a queue-based reference model of a 2-deep FIFO.
module tb_skid_buffer_rd;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
`ifdef SKID_BUFFER_STATS_EN
    logic [15:0]      xfer_count, stall_cycles;
    int               m_xfer, m_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] mq[$];   // reference model: words held, head first

    always #5 clk = ~clk;

    skid_buffer_rd #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef SKID_BUFFER_STATS_EN
        .xfer_count(xfer_count), .stall_cycles(stall_cycles),
`endif
        .out_data(out_data)
    );

    // One clock edge; the model follows the 2-deep FIFO rules with the inputs
    // applied before the edge, then outputs are sampled 1ns after it.
    task automatic tick();
        bit ih, oh;
        ih = in_valid && (mq.size() < 2);
        oh = out_ready && (mq.size() > 0);
        @(posedge clk);
`ifdef SKID_BUFFER_STATS_EN
        if (reset) begin
            m_xfer = 0; m_stall = 0;
        end else begin
            if (oh) m_xfer = (m_xfer + 1) % 65536;
            if (mq.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
        end
`endif
        if (reset || flush) mq.delete();
        else begin
            if (oh) void'(mq.pop_front());
            if (ih) mq.push_back(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; flush = 0; in_valid = 1; in_data = 64'hDEAD; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin reset = 0; in_valid = 0; end
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
                n_errors++;
                $display("FAIL reset[%0d]: out_valid=%b in_ready=%b out_data=%h, want 0 1 0",
                         i, out_valid, in_ready, out_data);
            end
        end
    endtask

    task automatic test_streaming();
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_data = WIDTH'(i);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
                n_errors++;
                $display("FAIL stream_data[%0d]: got v=%b d=%h want v=1 d=%h",
                         i, out_valid, out_data, WIDTH'(i));
            end
        end
        in_valid = 0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 0; in_valid = 1; in_data = 'hA; tick();
        in_data = 'hB; tick();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 'hA) begin
                n_errors++;
                $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b out_data=%h want 0 1 a",
                         i, in_ready, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1; tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 'hB || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release: out_valid=%b out_data=%h in_ready=%b want 1 b 1",
                     out_valid, out_data, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_data = 'hA; tick();
        in_data = 'hB; tick();
        flush = 1; in_data = 'hC; tick();
        flush = 0; in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL flush: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL flush_leak[%0d]: out_valid=%b out_data=%h want empty",
                         i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] nxt, exp_out;
        nxt = 'h100; exp_out = 'h100;
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = nxt;
            // Order check: each word the consumer takes must be the next in sequence.
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== exp_out) begin
                    n_errors++;
                    $display("FAIL rand_order[%0d]: got %h want %h", c, out_data, exp_out);
                end
                exp_out++;
            end
            if (in_valid && mq.size() < 2) nxt++;
            tick();
            n_checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                (mq.size() > 0 && out_data !== mq[0])) begin
                n_errors++;
                $display("FAIL rand_model[%0d]: v=%b r=%b d=%h want v=%b r=%b d=%h", c,
                         out_valid, in_ready, out_data, mq.size() > 0, mq.size() < 2,
                         (mq.size() > 0) ? mq[0] : '0);
            end
        end
        in_valid = 0;
    endtask

`ifdef SKID_BUFFER_STATS_EN
    task automatic test_stats();
        reset = 1; in_valid = 0; out_ready = 0; tick();
        reset = 0;
        in_valid = 1; in_data = 1; tick();
        in_valid = 0; tick(); tick(); tick();      // three stall cycles
        out_ready = 1; in_valid = 1;
        for (int i = 2; i <= 5; i++) begin in_data = WIDTH'(i); tick(); end
        in_valid = 0; tick();                       // fifth transfer
        n_checks++;
        if (xfer_count !== 16'd5 || stall_cycles !== 16'd3 ||
            xfer_count !== 16'(m_xfer) || stall_cycles !== 16'(m_stall)) begin
            n_errors++;
            $display("FAIL stats: xfer=%0d stall=%0d want 5 3", xfer_count, stall_cycles);
        end
        out_ready = 0; flush = 1; tick();
        flush = 0;
        n_checks++;
        if (xfer_count !== 16'd5 || stall_cycles !== 16'd3) begin
            n_errors++;
            $display("FAIL stats_flush: xfer=%0d stall=%0d want 5 3", xfer_count, stall_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_random();
`ifdef SKID_BUFFER_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/skid_buffer_rd.md
Name: skid_buffer_rd

Overview:
- Two-entry valid/ready pipeline buffer that moves a WIDTH-bit word from a producer stage to a consumer stage.
- It is the read-side counterpart of the enable-gated pipeline register. The consumer pulls data with out_ready; back-pressure reaches the producer through a registered in_ready.
- Sits between CPU pipeline stages, e.g. fetch->decode and the memory response path. Stalls never create a combinational ready path across stages.

Parameters:
- WIDTH, 64, data word width in bits

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk
- flush  input  1  synchronous; discards all buffered words
- in_valid  input  1  producer presents a word
- in_ready  output  1  buffer can accept a word; registered, no combinational input dependency
- in_data  input  WIDTH  producer word
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer takes the word this cycle
- out_data  output  WIDTH  head word; driven from a register

Behaviour:
- Handshakes:
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
  - Both are evaluated at the same edge.
- Storage: main register (drives out_data/out_valid) and skid register.
- States:
  - EMPTY: main invalid, skid invalid
  - ONE: main valid, skid invalid
  - FULL: main valid, skid valid
- Output decode: in_ready = (state != FULL); out_valid = (state != EMPTY).
- Transitions, in priority order (reset > flush > handshakes):
  - EMPTY + in hs -> ONE; main <= in_data.
  - ONE + in hs + out hs -> ONE; main <= in_data.
  - ONE + in hs, no out hs -> FULL; skid <= in_data.
  - ONE + out hs, no in hs -> EMPTY.
  - FULL + out hs -> ONE; main <= skid. No input is possible because in_ready=0.
  - Otherwise hold state, main and skid unchanged.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N; minimum 1 cycle.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Stall: while out_valid=1 and out_ready=0, out_data is stable across cycles.
- Simultaneous events:
  - in hs and out hs in ONE at the same edge: the new word replaces the head, and state stays ONE.
  - flush together with in_valid: the input word is also discarded; state -> EMPTY.
- Reset (also mid-transfer): state EMPTY, out_valid=0, in_ready=1, out_data=0, skid contents=0.
- Flush: state EMPTY, out_valid=0, in_ready=1 after the edge. Register contents are don't-care; the implementation zeroes them.
- When out_valid=0, out_data is don't-care; the implementation holds its last value.

Optional Feature:
- Macro: SKID_BUFFER_STATS_EN
- Defined:
  - Adds output port xfer_count, 16 bits.
  - Increments by 1 on each output handshake and wraps 16'hFFFF -> 0.
  - Cleared by reset only; flush does not clear it.
  - Adds output port stall_cycles, 16 bits. Increments each cycle with out_valid=1 and out_ready=0, and saturates at 16'hFFFF.
- Undefined: neither port exists; the rest of the behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1, in_data=64'hDEAD -> out_valid=0, in_ready=1, out_data=0 throughout and 1 cycle after release.
- Streaming: out_ready=1; send 0x1..0x8 on consecutive cycles -> out_data sequence 0x1..0x8, each one cycle after acceptance; in_ready stays 1.
- Back-pressure:
  - Stimulus: out_ready=0; send 0xA then 0xB.
  - Required while stalled: in_ready=0 after the second accept, and out_data holds 0xA.
  - Required on release: raise out_ready -> 0xA then 0xB delivered; in_ready=1 after the first drain.
- Flush: FULL with 0xA/0xB; assert flush together with in_valid=1 and in_data=0xC -> next cycle out_valid=0, in_ready=1; 0xC never appears.
- Random: random in_valid/out_ready for 1000 cycles with incrementing data -> the scoreboard sees an in-order, gap-free sequence.
- Stats, with SKID_BUFFER_STATS_EN defined: 5 transfers plus 3 stall cycles -> xfer_count=5, stall_cycles=3; a flush leaves both values unchanged.
